// File: rtl/score_bcd_pkg.sv
// Shared types and constants for the score/high-score BCD conversion scheduler.
package score_bcd_pkg;

    localparam int          NUM_DIGITS  = 4;
    localparam logic [15:0] MAX_DISPLAY = 16'd9999;

    typedef logic [3:0]                    bcd_digit_t;
    typedef bcd_digit_t [NUM_DIGITS-1:0]   bcd4_t;

    typedef enum logic [1:0] {IDLE, SHIFT, WRITE} sched_state_t;
    typedef enum logic       {CH_SCORE, CH_HI}    chan_t;

    // Bit k set when digit k and every higher digit are zero; ones digit always shown.
    function automatic logic [NUM_DIGITS-1:0] blank_mask(input bcd4_t d);
        logic [NUM_DIGITS-1:0] m;
        m[3] = (d[3] == 4'd0);
        m[2] = m[3] && (d[2] == 4'd0);
        m[1] = m[2] && (d[1] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/score_bcd_scheduler_engine.sv
// Iterative double-dabble engine: one add-3/shift-left iteration per step pulse.
import score_bcd_pkg::*;

module bcd_shift_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] operand,
    input  logic             step,
    output bcd4_t            result
);

    logic [4*NUM_DIGITS-1:0] bcd;
    logic [4*NUM_DIGITS-1:0] adj;
    logic [WIDTH-1:0]        bin;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Operand is pre-clamped to four digits, so the top BCD bit never overflows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd <= '0;
            bin <= '0;
        end else if (load) begin
            bcd <= '0;
            bin <= operand;
        end else if (step) begin
            bcd <= {adj[4*NUM_DIGITS-2:0], bin[WIDTH-1]};
            bin <= {bin[WIDTH-2:0], 1'b0};
        end
    end

    assign result = bcd;

endmodule

// File: rtl/score_bcd_scheduler.sv
// Arbitrates score/high-score requests onto one shared BCD engine and holds per-channel digits.
// Optional leading-zero blanking enabled by defining SCORE_LEADING_ZERO_BLANK_EN.
import score_bcd_pkg::*;

module score_bcd_scheduler #(
    parameter int WIDTH     = 16,
    parameter int MAX_VALUE = 9999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] score_value,
    input  logic             score_update,
    input  logic [WIDTH-1:0] hi_value,
    input  logic             hi_update,
    output logic [15:0]      score_digits,
    output logic [15:0]      hi_digits,
    output logic             score_valid,
    output logic             hi_valid,
    output logic             score_clamp,
    output logic             hi_clamp,
    output logic [3:0]       score_blank,
    output logic [3:0]       hi_blank,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    sched_state_t     state, next_state;
    chan_t            gnt, pick, last;
    logic             pend_s, pend_h;
    logic [WIDTH-1:0] shadow_s, shadow_h, shadow_sel, operand;
    logic [CW-1:0]    cnt;
    logic             cur_clamp, over;
    logic             load, step, done;
    bcd4_t            result;
    logic [3:0]       blank_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Both pending: serve the channel opposite to the last one written.
    always_comb begin
        next_state = state;
        pick       = gnt;
        load       = 1'b0;
        step       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (pend_s || pend_h) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                    if (pend_s && pend_h) pick = (last == CH_SCORE) ? CH_HI : CH_SCORE;
                    else                  pick = pend_s ? CH_SCORE : CH_HI;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) next_state = WRITE;
            end
            WRITE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign shadow_sel = (pick == CH_SCORE) ? shadow_s : shadow_h;
    assign over       = (shadow_sel > WIDTH'(MAX_VALUE));
    assign operand    = over ? WIDTH'(MAX_VALUE) : shadow_sel;
    assign busy       = (state != IDLE);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign blank_next = blank_mask(result);
`else
    assign blank_next = 4'b0000;
`endif

    bcd_shift_engine #(.WIDTH(WIDTH)) u_engine (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .operand (operand),
        .step    (step),
        .result  (result)
    );

    // A strobe on the grant edge keeps pending set so the new value converts next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_s       <= 1'b0;
            pend_h       <= 1'b0;
            shadow_s     <= '0;
            shadow_h     <= '0;
            gnt          <= CH_SCORE;
            last         <= CH_HI;
            cnt          <= '0;
            cur_clamp    <= 1'b0;
            score_digits <= '0;
            hi_digits    <= '0;
            score_valid  <= 1'b0;
            hi_valid     <= 1'b0;
            score_clamp  <= 1'b0;
            hi_clamp     <= 1'b0;
            score_blank  <= '0;
            hi_blank     <= '0;
        end else begin
            score_valid <= 1'b0;
            hi_valid    <= 1'b0;

            if (score_update) begin
                shadow_s <= score_value;
                pend_s   <= 1'b1;
            end else if (load && pick == CH_SCORE) begin
                pend_s <= 1'b0;
            end

            if (hi_update) begin
                shadow_h <= hi_value;
                pend_h   <= 1'b1;
            end else if (load && pick == CH_HI) begin
                pend_h <= 1'b0;
            end

            if (load) begin
                gnt       <= pick;
                cur_clamp <= over;
                cnt       <= '0;
            end else if (step) begin
                cnt <= cnt + 1'b1;
            end

            if (done) begin
                last <= gnt;
                if (gnt == CH_SCORE) begin
                    score_digits <= result;
                    score_clamp  <= cur_clamp;
                    score_blank  <= blank_next;
                    score_valid  <= 1'b1;
                end else begin
                    hi_digits <= result;
                    hi_clamp  <= cur_clamp;
                    hi_blank  <= blank_next;
                    hi_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_scheduler.sv
// Directed bench for score_bcd_scheduler: latency, clamp, arbitration, overwrite, reset, blanking.
module tb_score_bcd_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score_value, hi_value;
    logic        score_update, hi_update;
    logic [15:0] score_digits, hi_digits;
    logic        score_valid, hi_valid, score_clamp, hi_clamp, busy;
    logic [3:0]  score_blank, hi_blank;

    int errors = 0;
    int checks = 0;

    score_bcd_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .score_value  (score_value),
        .score_update (score_update),
        .hi_value     (hi_value),
        .hi_update    (hi_update),
        .score_digits (score_digits),
        .hi_digits    (hi_digits),
        .score_valid  (score_valid),
        .hi_valid     (hi_valid),
        .score_clamp  (score_clamp),
        .hi_clamp     (hi_clamp),
        .score_blank  (score_blank),
        .hi_blank     (hi_blank),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observe state after the next rising edge.
    task automatic step_obs();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present strobes for exactly one rising edge (edge N); returns just after edge N.
    task automatic drive(input logic s, input logic [15:0] sv, input logic h, input logic [15:0] hv);
        @(negedge clk);
        score_value  = sv;
        score_update = s;
        hi_value     = hv;
        hi_update    = h;
        @(posedge clk);
        #1;
        score_update = 1'b0;
        hi_update    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        score_value = '0; hi_value = '0; score_update = 1'b0; hi_update = 1'b0;
        do_reset();
        checks++; if (score_digits !== 16'h0000) begin errors++; $display("FAIL reset_score_digits: got %h want 0000", score_digits); end
        checks++; if (hi_digits !== 16'h0000) begin errors++; $display("FAIL reset_hi_digits: got %h want 0000", hi_digits); end
        checks++; if ({score_valid, hi_valid, score_clamp, hi_clamp} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {score_valid, hi_valid, score_clamp, hi_clamp}); end
        checks++; if ({score_blank, hi_blank} !== 8'h00) begin errors++; $display("FAIL reset_blank: got %h want 00", {score_blank, hi_blank}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        drive(1'b1, 16'd1234, 1'b0, 16'd0);
        for (int c = 1; c <= 18; c++) begin
            step_obs();
            if (c < 18) begin
                checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: cycle %0d got %b want 0", c, score_valid); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: cycle %0d got %b want 1", c, busy); end
            end
        end
        checks++; if (score_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", score_valid); end
        checks++; if (score_digits !== 16'h1234) begin errors++; $display("FAIL basic_digits: got %h want 1234", score_digits); end
        checks++; if (score_clamp !== 1'b0) begin errors++; $display("FAIL basic_clamp: got %b want 0", score_clamp); end
        checks++; if (hi_valid !== 1'b0 || hi_digits !== 16'h0000) begin errors++; $display("FAIL basic_hi_untouched: got %b/%h want 0/0000", hi_valid, hi_digits); end
        step_obs();
        checks++; if (score_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width: got %b want 0", score_valid); end
        checks++; if (score_digits !== 16'h1234) begin errors++; $display("FAIL basic_hold: got %h want 1234", score_digits); end
    endtask

    task automatic test_clamp();
        drive(1'b1, 16'd12000, 1'b0, 16'd0);
        repeat (18) step_obs();
        checks++; if (score_valid !== 1'b1) begin errors++; $display("FAIL clamp_valid: got %b want 1", score_valid); end
        checks++; if (score_digits !== 16'h9999) begin errors++; $display("FAIL clamp_digits: got %h want 9999", score_digits); end
        checks++; if (score_clamp !== 1'b1) begin errors++; $display("FAIL clamp_flag: got %b want 1", score_clamp); end
        drive(1'b1, 16'd9999, 1'b0, 16'd0);
        repeat (18) step_obs();
        checks++; if (score_digits !== 16'h9999) begin errors++; $display("FAIL edge9999_digits: got %h want 9999", score_digits); end
        checks++; if (score_clamp !== 1'b0) begin errors++; $display("FAIL edge9999_clamp: got %b want 0", score_clamp); end
        drive(1'b0, 16'd0, 1'b1, 16'd65535);
        repeat (18) step_obs();
        checks++; if (hi_valid !== 1'b1) begin errors++; $display("FAIL hiclamp_valid: got %b want 1", hi_valid); end
        checks++; if (hi_digits !== 16'h9999 || hi_clamp !== 1'b1) begin errors++; $display("FAIL hiclamp: got %h/%b want 9999/1", hi_digits, hi_clamp); end
        checks++; if (score_digits !== 16'h9999 || score_clamp !== 1'b0) begin errors++; $display("FAIL hiclamp_score_untouched: got %h/%b want 9999/0", score_digits, score_clamp); end
    endtask

    task automatic test_both();
        do_reset();
        drive(1'b1, 16'd42, 1'b1, 16'd9876);
        for (int c = 1; c <= 36; c++) begin
            step_obs();
            checks++; if (busy !== (c % 18 != 0)) begin errors++; $display("FAIL both_busy: cycle %0d got %b want %b", c, busy, (c % 18 != 0)); end
            checks++; if (score_valid !== (c == 18)) begin errors++; $display("FAIL both_score_valid: cycle %0d got %b want %b", c, score_valid, (c == 18)); end
            checks++; if (hi_valid !== (c == 36)) begin errors++; $display("FAIL both_hi_valid: cycle %0d got %b want %b", c, hi_valid, (c == 36)); end
            if (c == 18) begin
                checks++; if (score_digits !== 16'h0042) begin errors++; $display("FAIL both_score_digits: got %h want 0042", score_digits); end
                checks++; if (hi_digits !== 16'h0000) begin errors++; $display("FAIL both_hi_early: got %h want 0000", hi_digits); end
            end
        end
        checks++; if (hi_digits !== 16'h9876) begin errors++; $display("FAIL both_hi_digits: got %h want 9876", hi_digits); end
        checks++; if (score_digits !== 16'h0042) begin errors++; $display("FAIL both_score_hold: got %h want 0042", score_digits); end
    endtask

    task automatic test_overwrite();
        drive(1'b1, 16'd100, 1'b0, 16'd0);
        for (int c = 1; c <= 36; c++) begin
            step_obs();
            if (c == 4) begin
                score_value  = 16'd200;
                score_update = 1'b1;
            end
            if (c == 5) score_update = 1'b0;
            checks++; if (score_valid !== (c == 18 || c == 36)) begin errors++; $display("FAIL ovw_valid: cycle %0d got %b want %b", c, score_valid, (c == 18 || c == 36)); end
            if (c == 18) begin
                checks++; if (score_digits !== 16'h0100) begin errors++; $display("FAIL ovw_first: got %h want 0100", score_digits); end
            end
        end
        checks++; if (score_digits !== 16'h0200) begin errors++; $display("FAIL ovw_second: got %h want 0200", score_digits); end
        checks++; if (hi_digits !== 16'h9876) begin errors++; $display("FAIL ovw_hi_untouched: got %h want 9876", hi_digits); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'd5555, 1'b0, 16'd0);
        repeat (8) step_obs();
        #1 reset = 1'b1;
        #1;
        checks++; if (score_digits !== 16'h0000 || hi_digits !== 16'h0000) begin errors++; $display("FAIL rstmid_digits: got %h/%h want 0000/0000", score_digits, hi_digits); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            step_obs();
            checks++; if (score_valid !== 1'b0 || hi_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_resume: cycle %0d got valid %b%b busy %b want 000", c, score_valid, hi_valid, busy); end
        end
        checks++; if (score_digits !== 16'h0000) begin errors++; $display("FAIL rstmid_after: got %h want 0000", score_digits); end
    endtask

    task automatic test_blank();
        logic [15:0] vals [3];
        logic [15:0] exp_d [3];
        logic [3:0]  exp_b [3];
        vals  = '{16'd0, 16'd7, 16'd305};
        exp_d = '{16'h0000, 16'h0007, 16'h0305};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        exp_b = '{4'b1110, 4'b1110, 4'b1000};
`else
        exp_b = '{4'b0000, 4'b0000, 4'b0000};
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i], 1'b0, 16'd0);
            repeat (18) step_obs();
            checks++; if (score_valid !== 1'b1 || score_digits !== exp_d[i]) begin errors++; $display("FAIL blank_digits[%0d]: got %b/%h want 1/%h", i, score_valid, score_digits, exp_d[i]); end
            checks++; if (score_blank !== exp_b[i]) begin errors++; $display("FAIL blank_mask[%0d]: got %b want %b", i, score_blank, exp_b[i]); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic();
        test_clamp();
        test_both();
        test_overwrite();
        test_reset_mid();
        test_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
